// File: rtl/bus_pkg.sv
// Shared encodings for the load/store unit to Wishbone bridge.
package bus_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_MISAL = 2'b01;
    localparam logic [1:0] ERR_BUS   = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    typedef enum logic [1:0] {StIdle, StStrobe, StWait, StFinish} state_e;

endpackage

// File: rtl/wb_lsu_align.sv
// Lane steering for the bridge: byte selects and store shift on the request side,
// load extract and sign/zero extension on the response side.
module wb_lsu_align
    import bus_pkg::*;
(
    input  logic [1:0]  req_off,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        req_misal,
    output logic [3:0]  req_sel,
    output logic [31:0] req_wdat,
    input  logic [1:0]  rsp_off,
    input  logic [1:0]  rsp_size,
    input  logic        rsp_unsigned,
    input  logic [31:0] rsp_data,
    output logic [31:0] rsp_rdata
);

    logic [3:0]  base_sel;
    logic [31:0] shifted;

    always_comb begin
        base_sel  = 4'b1111;
        req_misal = (req_off != 2'b00);
        // Size 11 falls through to the word encoding.
        case (req_size)
            SIZE_B: begin
                base_sel  = 4'b0001;
                req_misal = 1'b0;
            end
            SIZE_H: begin
                base_sel  = 4'b0011;
                req_misal = req_off[0];
            end
            default: begin
                base_sel  = 4'b1111;
                req_misal = (req_off != 2'b00);
            end
        endcase
        req_sel  = base_sel << req_off;
        req_wdat = req_wdata << {req_off, 3'b000};
    end

    always_comb begin
        shifted = rsp_data >> {rsp_off, 3'b000};
        case (rsp_size)
            SIZE_B: begin
                rsp_rdata = rsp_unsigned ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                rsp_rdata = rsp_unsigned ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: rsp_rdata = shifted;
        endcase
    end

endmodule

// File: rtl/wb_lsu_bridge.sv
// Converts one core load/store request into a single pipelined Wishbone B4 cycle,
// with misalignment, bus-error and timeout reporting.
module wb_lsu_bridge
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [1:0]  core_size_i,
    input  logic        core_unsigned_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_busy_o,
    output logic        core_done_o,
    output logic [1:0]  core_err_o,
    output logic [31:0] core_rdata_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i
);

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        we_q, uns_q;
    logic [1:0]  size_q, off_q;
    logic [31:0] adr_q, wdat_q;
    logic [3:0]  sel_q;
    logic [7:0]  cnt_q;

    logic        accept;
    logic [1:0]  err_d;
    logic        req_misal;
    logic [3:0]  req_sel;
    logic [31:0] req_wdat, rsp_rdata;

    logic        cyc_d, stb_d, we_d, busy_d, done_d;
    logic [31:0] adr_d, dat_d, rdata_d;
    logic [3:0]  sel_d;
    logic [1:0]  core_err_d;

    // FINISH already reports not-busy, so a held request is taken there too.
    assign accept = core_req_i && (state_q == StIdle || state_q == StFinish);

    wb_lsu_align u_align (
        .req_off      (core_addr_i[1:0]),
        .req_size     (core_size_i),
        .req_wdata    (core_wdata_i),
        .req_misal    (req_misal),
        .req_sel      (req_sel),
        .req_wdat     (req_wdat),
        .rsp_off      (off_q),
        .rsp_size     (size_q),
        .rsp_unsigned (uns_q),
        .rsp_data     (wb_dat_i),
        .rsp_rdata    (rsp_rdata)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = ERR_OK;
        unique case (state_q)
            StIdle, StFinish: begin
                if (core_req_i) begin
                    if (req_misal) begin
                        state_d = StFinish;
                        err_d   = ERR_MISAL;
                    end else begin
                        state_d = StStrobe;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StStrobe: begin
                if (!wb_stall_i) state_d = StWait;
            end
            StWait: begin
                if (wb_err_i) begin
                    state_d = StFinish;
                    err_d   = ERR_BUS;
                end else if (wb_ack_i) begin
                    state_d = StFinish;
                    err_d   = ERR_OK;
                end else if (cnt_q == CntLast) begin
                    state_d = StFinish;
                    err_d   = ERR_TMO;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cyc_d      = (state_d == StStrobe) || (state_d == StWait);
        stb_d      = (state_d == StStrobe);
        busy_d     = cyc_d;
        done_d     = (state_d == StFinish);
        core_err_d = done_d ? err_d : ERR_OK;
        we_d       = 1'b0;
        adr_d      = '0;
        dat_d      = '0;
        sel_d      = '0;
        if (cyc_d) begin
            if (accept) begin
                we_d  = core_we_i;
                adr_d = {core_addr_i[31:2], 2'b00};
                dat_d = req_wdat;
                sel_d = req_sel;
            end else begin
                we_d  = we_q;
                adr_d = adr_q;
                dat_d = wdat_q;
                sel_d = sel_q;
            end
        end
        rdata_d = '0;
        if (state_q == StWait && done_d && err_d == ERR_OK && !we_q) rdata_d = rsp_rdata;
    end

    // Request latches and the timeout counter; stall cycles never reach the counter.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            we_q   <= 1'b0;
            uns_q  <= 1'b0;
            size_q <= SIZE_B;
            off_q  <= 2'b00;
            adr_q  <= '0;
            wdat_q <= '0;
            sel_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (accept) begin
                we_q   <= core_we_i;
                uns_q  <= core_unsigned_i;
                size_q <= core_size_i;
                off_q  <= core_addr_i[1:0];
                adr_q  <= {core_addr_i[31:2], 2'b00};
                wdat_q <= req_wdat;
                sel_q  <= req_sel;
            end
            if (state_q == StStrobe) begin
                cnt_q <= '0;
            end else if (state_q == StWait) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= '0;
            wb_dat_o     <= '0;
            wb_sel_o     <= '0;
            core_busy_o  <= 1'b0;
            core_done_o  <= 1'b0;
            core_err_o   <= ERR_OK;
            core_rdata_o <= '0;
        end else begin
            wb_cyc_o     <= cyc_d;
            wb_stb_o     <= stb_d;
            wb_we_o      <= we_d;
            wb_adr_o     <= adr_d;
            wb_dat_o     <= dat_d;
            wb_sel_o     <= sel_d;
            core_busy_o  <= busy_d;
            core_done_o  <= done_d;
            core_err_o   <= core_err_d;
            core_rdata_o <= rdata_d;
        end
    end

endmodule

// File: tb/tb_wb_lsu_bridge.sv
// Self-checking bench for wb_lsu_bridge: fixed vectors, corner sequences and random
// accesses against an arithmetic reference model.
module tb_wb_lsu_bridge;

    localparam int TMO = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        core_req_i, core_we_i, core_unsigned_i;
    logic [31:0] core_addr_i, core_wdata_i;
    logic [1:0]  core_size_i;
    logic        core_busy_o, core_done_o;
    logic [1:0]  core_err_o;
    logic [31:0] core_rdata_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i, wb_stall_i;

    int n_chk = 0;
    int n_err = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_lsu_bridge #(.TIMEOUT(TMO)) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .core_req_i      (core_req_i),
        .core_we_i       (core_we_i),
        .core_addr_i     (core_addr_i),
        .core_size_i     (core_size_i),
        .core_unsigned_i (core_unsigned_i),
        .core_wdata_i    (core_wdata_i),
        .core_busy_o     (core_busy_o),
        .core_done_o     (core_done_o),
        .core_err_o      (core_err_o),
        .core_rdata_o    (core_rdata_o),
        .wb_cyc_o        (wb_cyc_o),
        .wb_stb_o        (wb_stb_o),
        .wb_we_o         (wb_we_o),
        .wb_adr_o        (wb_adr_o),
        .wb_dat_o        (wb_dat_o),
        .wb_sel_o        (wb_sel_o),
        .wb_dat_i        (wb_dat_i),
        .wb_ack_i        (wb_ack_i),
        .wb_err_i        (wb_err_i),
        .wb_stall_i      (wb_stall_i)
    );

    // resp: 0 = ack, 1 = err, 2 = ack and err together, 3 = silent slave
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wd;
        int          resp;
        logic [31:0] sdat;
        logic [3:0]  esel;
        logic [31:0] edat;
        logic [31:0] erd;
        logic [1:0]  eerr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Reference: byte count and offset arithmetic, no lane tables.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          n, off;
        logic [63:0] u, mask;
        r    = v;
        n    = (v.size == 2'd0) ? 1 : (v.size == 2'd1) ? 2 : 4;
        off  = int'(v.addr % 4);
        r.esel = 4'(((1 << n) - 1) << off);
        r.edat = 32'({32'h0, v.wd} << (8 * off));
        mask = (64'd1 << (8 * n)) - 64'd1;
        u    = ({32'h0, v.sdat} >> (8 * off)) & mask;
        if (!v.uns && n < 4 && u >= (64'd1 << (8 * n - 1))) u = u - (64'd1 << (8 * n));
        r.erd = u[31:0];
        if ((v.addr % n) != 0)            r.eerr = 2'b01;
        else if (v.resp == 1 || v.resp == 2) r.eerr = 2'b10;
        else if (v.resp == 3)             r.eerr = 2'b11;
        else                              r.eerr = 2'b00;
        if (r.eerr != 2'b00 || v.we) r.erd = 32'h0;
        return r;
    endfunction

    // Starts at a negedge; cycle 1 is the cycle after the accepting edge.
    task automatic access(input vec_t v, input int stalls, input int lat, input string name);
        int   c, done_at;
        bit   seen, bad, emis, exp_cyc, exp_stb;
        emis    = (v.eerr == 2'b01);
        done_at = emis ? 1 : (v.resp == 3 ? stalls + 2 + TMO : stalls + 3 + lat);
        core_req_i      = 1'b1;
        core_we_i       = v.we;
        core_addr_i     = v.addr;
        core_size_i     = v.size;
        core_unsigned_i = v.uns;
        core_wdata_i    = v.wd;
        @(negedge wb_clk_i);
        core_req_i = 1'b0;
        c    = 1;
        seen = 0;
        bad  = 0;
        while (!seen && c <= done_at + 4) begin
            if (core_done_o === 1'b1) begin
                seen = 1;
            end else begin
                if (c == 1 && !emis) begin
                    chk({name, " sel"}, {28'h0, wb_sel_o}, {28'h0, v.esel});
                    chk({name, " adr"}, wb_adr_o, {v.addr[31:2], 2'b00});
                    chk({name, " we"}, {31'h0, wb_we_o}, {31'h0, v.we});
                    if (v.we) chk({name, " dat"}, wb_dat_o, v.edat);
                end
                exp_cyc = !emis;
                exp_stb = !emis && (c <= stalls + 1);
                if (wb_cyc_o !== exp_cyc || wb_stb_o !== exp_stb || core_busy_o !== exp_cyc)
                    bad = 1;
                wb_stall_i = !emis && (c <= stalls);
                wb_ack_i   = (v.resp == 0 || v.resp == 2) && (c == stalls + 2 + lat);
                wb_err_i   = (v.resp == 1 || v.resp == 2) && (c == stalls + 2 + lat);
                wb_dat_i   = v.sdat;
                @(negedge wb_clk_i);
                c++;
            end
        end
        chk({name, " done cycle"}, seen ? 32'(c) : 32'h0, 32'(done_at));
        chk({name, " handshake"}, {31'h0, bad}, 32'h0);
        chk({name, " err"}, {30'h0, core_err_o}, {30'h0, v.eerr});
        chk({name, " rdata"}, core_rdata_o, v.erd);
        chk({name, " idle bus"}, {30'h0, wb_cyc_o, core_busy_o}, 32'h0);
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
        wb_stall_i = 1'b0;
        @(negedge wb_clk_i);
        chk({name, " done pulse"}, {31'h0, core_done_o}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   r;
        bit   bad;

        vecs[0] = '{1'b1, 32'h2018, 2'd2, 1'b0, 32'h0000_0100, 0, 32'h0,
                    4'b1111, 32'h0000_0100, 32'h0, 2'b00};
        vecs[1] = '{1'b0, 32'h2011, 2'd0, 1'b0, 32'h0, 0, 32'h0000_8000,
                    4'b0010, 32'h0, 32'hFFFF_FF80, 2'b00};
        vecs[2] = '{1'b0, 32'h2011, 2'd0, 1'b1, 32'h0, 0, 32'h0000_8000,
                    4'b0010, 32'h0, 32'h0000_0080, 2'b00};
        vecs[3] = '{1'b1, 32'h2012, 2'd1, 1'b0, 32'h0000_1234, 0, 32'h0,
                    4'b1100, 32'h1234_0000, 32'h0, 2'b00};
        vecs[4] = '{1'b0, 32'h2012, 2'd2, 1'b0, 32'h0, 0, 32'hAAAA_5555,
                    4'b0000, 32'h0, 32'h0, 2'b01};
        vecs[5] = '{1'b0, 32'h2010, 2'd2, 1'b0, 32'h0, 2, 32'h1234_5678,
                    4'b1111, 32'h0, 32'h0, 2'b10};
        vecs[6] = '{1'b0, 32'h2012, 2'd1, 1'b0, 32'h0, 0, 32'h8001_0000,
                    4'b1100, 32'h0, 32'hFFFF_8001, 2'b00};
        vecs[7] = '{1'b0, 32'h2014, 2'd3, 1'b0, 32'h0, 0, 32'hDEAD_BEEF,
                    4'b1111, 32'h0, 32'hDEAD_BEEF, 2'b00};

        wb_rst_i        = 1'b0;
        core_req_i      = 1'b0;
        core_we_i       = 1'b0;
        core_addr_i     = 32'h0;
        core_size_i     = 2'd0;
        core_unsigned_i = 1'b0;
        core_wdata_i    = 32'h0;
        wb_dat_i        = 32'h0;
        wb_ack_i        = 1'b0;
        wb_err_i        = 1'b0;
        wb_stall_i      = 1'b0;

        #12;
        chk("reset ctrl", {22'h0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, core_busy_o,
                           core_done_o, core_err_o}, 32'h0);
        chk("reset adr", wb_adr_o, 32'h0);
        chk("reset dat", wb_dat_o, 32'h0);
        chk("reset rdata", core_rdata_o, 32'h0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);

        for (int i = 0; i < 8; i++) access(vecs[i], 0, 0, $sformatf("vec%0d", i));

        // Silent slave with three stall cycles: done 20 cycles after stb rises.
        v = '{1'b0, 32'h2010, 2'd2, 1'b0, 32'h0, 3, 32'h0, 4'b1111, 32'h0, 32'h0, 2'b11};
        access(v, 3, 0, "timeout");

        // Responses outside WAIT must not complete anything.
        wb_ack_i = 1'b1;
        wb_err_i = 1'b1;
        @(negedge wb_clk_i);
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        chk("idle ack ignored", {30'h0, core_done_o, wb_cyc_o}, 32'h0);
        @(negedge wb_clk_i);
        chk("idle ack ignored 2", {31'h0, core_done_o}, 32'h0);

        // Held request is taken again in the FINISH cycle.
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_addr_i = 32'h2010;
        core_size_i = 2'd2;
        wb_dat_i    = 32'h1122_3344;
        @(negedge wb_clk_i);
        chk("b2b first cyc", {31'h0, wb_cyc_o}, 32'h1);
        @(negedge wb_clk_i);
        wb_ack_i = 1'b1;
        @(negedge wb_clk_i);
        wb_ack_i = 1'b0;
        chk("b2b first done", {30'h0, core_done_o, core_busy_o}, 32'h2);
        chk("b2b first rdata", core_rdata_o, 32'h1122_3344);
        wb_dat_i = 32'h5566_7788;
        @(negedge wb_clk_i);
        chk("b2b second strobe", {30'h0, wb_cyc_o, wb_stb_o}, 32'h3);
        core_req_i = 1'b0;
        @(negedge wb_clk_i);
        wb_ack_i = 1'b1;
        @(negedge wb_clk_i);
        wb_ack_i = 1'b0;
        chk("b2b second done", {31'h0, core_done_o}, 32'h1);
        chk("b2b second rdata", core_rdata_o, 32'h5566_7788);
        @(negedge wb_clk_i);

        // Reset during WAIT drops the bus without waiting for a clock edge.
        core_req_i   = 1'b1;
        core_we_i    = 1'b1;
        core_addr_i  = 32'h2018;
        core_size_i  = 2'd2;
        core_wdata_i = 32'h0000_0100;
        @(negedge wb_clk_i);
        core_req_i = 1'b0;
        @(negedge wb_clk_i);
        chk("pre-reset wait", {30'h0, wb_cyc_o, wb_stb_o}, 32'h2);
        #2;
        wb_rst_i = 1'b0;
        #1;
        chk("async reset cyc", {29'h0, wb_cyc_o, wb_stb_o, core_busy_o}, 32'h0);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge wb_clk_i);
            if (core_done_o !== 1'b0) bad = 1;
        end
        chk("no done in reset", {31'h0, bad}, 32'h0);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        chk("no done after reset", {31'h0, core_done_o}, 32'h0);
        v = model('{1'b0, 32'h2010, 2'd2, 1'b0, 32'h0, 0, 32'hCAFE_F00D,
                    4'h0, 32'h0, 32'h0, 2'b00});
        access(v, 0, 0, "post-reset load");

        for (int i = 0; i < 40; i++) begin
            v.we   = 1'($urandom % 2);
            v.addr = 32'h2000 + ($urandom % 64);
            v.size = 2'($urandom % 4);
            v.uns  = 1'($urandom % 2);
            v.wd   = $urandom;
            v.sdat = $urandom;
            r      = $urandom % 10;
            v.resp = (r < 6) ? 0 : (r == 6 || r == 7) ? 1 : (r == 8) ? 2 : 3;
            v      = model(v);
            access(v, $urandom % 4, $urandom % 4, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
